// File: rtl/thermo_encoder_pipe.sv
// Pipelined thermometer-to-binary encoder for the TDC fine-time path (capture, check/correct, count).
// Define THERMO_BUBBLE_CORRECT_EN to enable the 3-tap majority bubble filter in stage 1.
module thermo_encoder_pipe #(
  parameter int unsigned N_TAPS = 32,
  parameter int unsigned BIN_W  = $clog2(N_TAPS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [N_TAPS-1:0] thermo,
  output logic              out_valid,
  output logic [BIN_W-1:0]  bin,
  output logic              bubble_err,
  output logic              overflow
);

  logic [N_TAPS-1:0] s0_data;
  logic              s0_valid;
  logic [N_TAPS-1:0] s1_data;
  logic [N_TAPS-1:0] s1_next;
  logic              s1_valid;
  logic              s1_err;
  logic              raw_err;
  logic [BIN_W-1:0]  ones;

  // A 0 tap followed by a 1 tap anywhere means the raw sample is not a clean code.
  always_comb begin
    raw_err = |(~s0_data[N_TAPS-2:0] & s0_data[N_TAPS-1:1]);
  end

`ifdef THERMO_BUBBLE_CORRECT_EN
  // Virtual tap below bit 0 reads as 1, virtual tap above the top reads as 0.
  logic [N_TAPS+1:0] ext;
  always_comb begin
    ext     = {1'b0, s0_data, 1'b1};
    s1_next = '0;
    for (int unsigned i = 0; i < N_TAPS; i++) begin
      s1_next[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
    end
  end
`else
  always_comb begin
    s1_next = s0_data;
  end
`endif

  always_comb begin
    ones = '0;
    for (int unsigned i = 0; i < N_TAPS; i++) begin
      ones = ones + BIN_W'(s1_data[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_data    <= '0;
      s0_valid   <= 1'b0;
      s1_data    <= '0;
      s1_valid   <= 1'b0;
      s1_err     <= 1'b0;
      out_valid  <= 1'b0;
      bin        <= '0;
      bubble_err <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      s0_valid <= in_valid;
      if (in_valid) begin
        s0_data <= thermo;
      end

      s1_valid <= s0_valid;
      if (s0_valid) begin
        s1_data <= s1_next;
        s1_err  <= raw_err;
      end

      // Outputs only move on a real result so they hold through gaps.
      out_valid <= s1_valid;
      if (s1_valid) begin
        bin        <= ones;
        overflow   <= (s1_data == '1);
        bubble_err <= s1_err;
      end
    end
  end

endmodule

// File: doc/thermo_encoder_pipe.md
Name: thermo_encoder_pipe

Overview:
- Parametrised, pipelined thermometer-to-binary encoder for the TDC fine-time path.
- Captures the delay-line tap snapshot when its valid strobe is asserted.
- Optionally repairs single-tap bubbles, counts ones, and flags bubble and overflow conditions.
- Sits between the tapped-delay-line sampling flops and the coarse/fine time-stamp assembler. Supports one conversion per clock, fully pipelined.

Parameters:
- N_TAPS, 32, number of thermometer taps; legal range 4..256.
- BIN_W, $clog2(N_TAPS+1), output code width. Must hold the value N_TAPS; 6 for the default.

Ports:
- clk  input  1  conversion clock; all registers update on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  thermo holds a sample to convert this cycle.
- thermo  input  N_TAPS  thermometer code; bit 0 is the first tap.
- out_valid  output  1  bin and the flags hold a new result; high for one cycle per accepted sample.
- bin  output  BIN_W  number of ones in the (corrected) code, 0..N_TAPS.
- bubble_err  output  1  the raw sample was not a clean thermometer code.
- overflow  output  1  all N_TAPS taps were 1, so the hit is beyond the delay-line range.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n is low, all pipeline registers clear at once: out_valid=0, bin=0, bubble_err=0, overflow=0, internal valids=0.
- Stage 0 (capture): when in_valid=1 at rising edge n, register thermo into s0_data and set s0_valid=1. When in_valid=0, s0_valid=0 and s0_data holds its value.
- Stage 1 (check/correct), at edge n+1:
  - raw_err = OR over i=0..N_TAPS-2 of (~s0_data[i] & s0_data[i+1]).
  - Correction per Optional Feature; result goes to s1_data.
  - s1_valid <= s0_valid.
- Stage 2 (count), at edge n+2:
  - bin <= popcount(s1_data), computed at BIN_W width with no truncation.
  - overflow <= (s1_data == all ones).
  - bubble_err <= registered raw_err.
  - out_valid <= s1_valid.
- Latency: in_valid high at edge n gives out_valid high during the cycle after edge n+2.
- Throughput: samples on consecutive cycles give consecutive outputs in the same order. No backpressure; the downstream block must accept every out_valid.
- Hold: when out_valid=0, bin, bubble_err and overflow keep their last value and carry no meaning.
- Flags are evaluated only on the captured sample. They are never sticky and never accumulate across samples.
- Boundary values:
  - thermo=0 gives bin=0, overflow=0, bubble_err=0.
  - All ones gives bin=N_TAPS, overflow=1, bubble_err=0.
- Reset mid-operation: samples in flight are discarded. out_valid does not assert for them after rst_n deasserts. The first in_valid after release behaves as from a fresh reset.
- Synthesis: purely synchronous datapath with no latches. The popcount may be an adder tree, provided it closes timing in one stage.

Optional Feature:
- Macro: THERMO_BUBBLE_CORRECT_EN.
- Defined: stage 1 applies a 3-input majority filter, s1_data[i] = MAJ(s0_data[i-1], s0_data[i], s0_data[i+1]).
  - Virtual tap s0_data[-1] is 1.
  - Virtual tap s0_data[N_TAPS] is 0.
  - Isolated single-tap bubbles and spikes are removed before counting.
- Undefined: s1_data = s0_data with no filter.
- bubble_err reports the raw, uncorrected code in both builds. Latency is identical in both builds.

Test Plan (N_TAPS=32):
- Clean code: after reset, thermo=32'h0000_00FF with in_valid for 1 cycle -> out_valid pulses once, 3 edges later; bin=8, bubble_err=0, overflow=0.
- Both extremes: thermo=32'hFFFF_FFFF -> bin=32, overflow=1. Then thermo=32'h0 -> bin=0, overflow=0.
- Single bubble: thermo=32'h0000_00FB -> bubble_err=1 in both builds. bin=8 with THERMO_BUBBLE_CORRECT_EN, bin=7 without.
- Back-to-back: 32'h1, 32'h3, 32'hFFFF, 32'h7FFF_FFFF on 4 consecutive cycles -> out_valid high 4 consecutive cycles with bin=1, 2, 16, 31 in order.
- Gaps: in_valid pattern 1,0,0,1 -> out_valid reproduces 1,0,0,1 delayed by the pipeline; bin holds its value during the gaps.
- Reset mid-flight: present 32'hFF, then pull rst_n low one cycle later for 2 cycles -> all outputs 0 immediately, and no out_valid ever appears for that sample.
